// File: rtl/reset_sequencer.sv
// Turns an asynchronous PLL lock into ordered per-domain synchronous resets.
// Optional feature: define RST_SEQ_SW_REQ_EN to add the sw_reset_req restart input.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DOMAINS = 3,
  parameter int LOCK_FILTER = 16,
  parameter int RELEASE_GAP = 8
) (
  input  logic                   system_clock,
  input  logic                   system_reset,
  input  logic                   lock_in,
`ifdef RST_SEQ_SW_REQ_EN
  input  logic                   sw_reset_req,
`endif
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   seq_done
);

  localparam int MAX_CNT = (LOCK_FILTER > RELEASE_GAP) ? LOCK_FILTER : RELEASE_GAP;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(RELEASE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    FILTER  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [NUM_DOMAINS-1:0] r_rstOut;
  logic                   r_done;

  logic                   w_lockS;
  state_t                 w_stateNext;
  logic [CW-1:0]          w_cntNext;
  logic [IW-1:0]          w_idxNext;
  logic [NUM_DOMAINS-1:0] w_rstNext;
  logic                   w_doneNext;
  logic [NUM_DOMAINS-1:0] w_rstCleared;

  assign w_lockS      = r_sync[SYNC_STAGES-1];
  assign w_rstCleared = r_rstOut & ~(NUM_DOMAINS'(1) << r_idx);

`ifdef RST_SEQ_SW_REQ_EN
  // The request is only honoured when it arrives while domains are releasing or running.
  logic r_swReq;

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      r_swReq <= 1'b0;
    end else begin
      r_swReq <= sw_reset_req && w_lockS && ((r_state == RELEASE) || (r_state == RUN));
    end
  end
`endif

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      r_sync   <= '0;
      r_state  <= HOLD;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_rstOut <= '1;
      r_done   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], lock_in};
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_idx    <= w_idxNext;
      r_rstOut <= w_rstNext;
      r_done   <= w_doneNext;
    end
  end

  // Lock loss outranks everything, including a release due on the same edge.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_idxNext   = r_idx;
    w_rstNext   = r_rstOut;
    w_doneNext  = r_done;

    if (!w_lockS) begin
      w_stateNext = HOLD;
      w_cntNext   = '0;
      w_idxNext   = '0;
      w_rstNext   = '1;
      w_doneNext  = 1'b0;
    end
`ifdef RST_SEQ_SW_REQ_EN
    else if (r_swReq) begin
      w_stateNext = FILTER;
      w_cntNext   = '0;
      w_idxNext   = '0;
      w_rstNext   = '1;
      w_doneNext  = 1'b0;
    end
`endif
    else begin
      case (r_state)
        HOLD: begin
          w_stateNext = FILTER;
          w_cntNext   = '0;
        end
        FILTER: begin
          if (r_cnt == FILT_LAST) begin
            w_stateNext = RELEASE;
            w_cntNext   = '0;
            w_idxNext   = '0;
          end else begin
            w_cntNext = r_cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (r_cnt == GAP_LAST) begin
            w_rstNext = w_rstCleared;
            w_cntNext = '0;
            if (r_idx == IDX_LAST) begin
              w_stateNext = RUN;
              w_doneNext  = 1'b1;
              w_idxNext   = '0;
            end else begin
              w_idxNext = r_idx + IW'(1);
            end
          end else begin
            w_cntNext = r_cnt + CW'(1);
          end
        end
        RUN: begin
          w_stateNext = RUN;
        end
        default: begin
          w_stateNext = HOLD;
        end
      endcase
    end
  end

  assign rst_out  = r_rstOut;
  assign seq_done = r_done;

endmodule
